load_sequencer: RTL and testbench

//   Upstream feeder for the N-bit edge-loaded register. Accepts words over a valid/ready handshake
//   and buffers them in a small FIFO. Presents each word on OutData a full cycle before a one-cycle

---
 rtl/ldseq_pkg.sv | 18 +
 rtl/sync_fifo.sv | 74 +++++++
 rtl/load_sequencer.sv | 158 +++++++++++++++
 tb/tb_load_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ldseq_pkg.sv
// Shared definitions for the load sequencer: FSM state encoding and the
// occupancy-counter width helper.
package ldseq_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_LOAD  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO used as the word buffer of the load sequencer.
// Pointers are $clog2(DEPTH) bits wide and wrap naturally. The registered
// occupancy counter distinguishes full from empty. A push is ignored when the
// FIFO is full, and a pop is ignored when it is empty. A flush empties the
// FIFO and overrides any push or pop on the same edge.
module sync_fifo
    import ldseq_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic                      flush_i,
    input  logic [N-1:0]              wdata_i,
    output logic [N-1:0]              rdata_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [N-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    // Occupancy next-state: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, with a flush that returns them to empty.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage write. The storage itself needs no reset because the
    // occupancy counter controls which entries are valid.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/load_sequencer.sv
// Load sequencer: this block feeds an N-bit edge-loaded register.
//
// Words arrive over a valid/ready handshake and are buffered in sync_fifo.
// For each word, the block does the following:
//   1. It presents the word on OutData for one cycle (SETUP).
//   2. It pulses Load for one cycle (LOAD).
//   3. It holds OutData for GAP cycles (HOLD).
// A ClearReq produces a one-cycle Clear pulse and flushes the sequencer.
//
// Handshake: a word transfers on a rising edge where InValid && InReady,
// unless ClearReq is also high. InReady depends only on the registered
// occupancy. InValid may be dropped at any time.
//
// Optional feature (macro LOAD_SEQUENCER_OVF_EN): this adds a sticky Overflow
// output. Overflow is set when a word is offered while the FIFO is full.
// ClearReq or reset clears it.
module load_sequencer
    import ldseq_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                      Clock,
    input  logic                      ResetN,
    input  logic                      InValid,
    input  logic [N-1:0]              InData,
    output logic                      InReady,
    input  logic                      ClearReq,
    output logic                      Load,
    output logic                      Clear,
    output logic [N-1:0]              OutData,
    output logic [cnt_w(DEPTH)-1:0]   Count,
    output logic                      Busy
`ifdef LOAD_SEQUENCER_OVF_EN
    ,
    output logic                      Overflow
`endif
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int GAP_W = $clog2(GAP + 1);

    state_t           state_q, state_d;
    logic             load_q, load_d;
    logic             clear_q, clear_d;
    logic [N-1:0]     out_q, out_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             push;
    logic             pop;
    logic [N-1:0]     head;
    logic [CNT_W-1:0] fifo_count;

    // ClearReq blocks both push and pop, so the flush always wins.
    assign push = InValid && InReady && !ClearReq;
    assign pop  = (state_q == ST_LOAD) && !ClearReq;

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clock),
        .rst_ni  (ResetN),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (ClearReq),
        .wdata_i (InData),
        .rdata_o (head),
        .count_o (fifo_count)
    );

    // FSM next-state logic. The registered outputs are computed for the
    // state being entered, so they change together with the state.
    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        clear_d = 1'b0;
        out_d   = out_q;
        gap_d   = gap_q;
        if (ClearReq) begin
            state_d = ST_IDLE;
            clear_d = 1'b1;
            out_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_count != '0) begin
                        state_d = ST_SETUP;
                        out_d   = head;
                    end
                end
                ST_SETUP: begin
                    state_d = ST_LOAD;
                    load_d  = 1'b1;
                end
                ST_LOAD: begin
                    state_d = ST_HOLD;
                    gap_d   = GAP_W'(GAP - 1);
                end
                ST_HOLD: begin
                    if (gap_q != '0) begin
                        gap_d = gap_q - 1'b1;
                    end else if (fifo_count != '0) begin
                        // The head already advanced when LOAD was exited.
                        state_d = ST_SETUP;
                        out_d   = head;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, gap counter, and output registers.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
            load_q  <= 1'b0;
            clear_q <= 1'b0;
            out_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            clear_q <= clear_d;
            out_q   <= out_d;
            gap_q   <= gap_d;
        end
    end

`ifdef LOAD_SEQUENCER_OVF_EN
    logic ovf_q;

    // Sticky flag: set when a word is offered while the FIFO is full.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            ovf_q <= 1'b0;
        end else if (ClearReq) begin
            ovf_q <= 1'b0;
        end else if (InValid && !InReady) begin
            ovf_q <= 1'b1;
        end
    end

    assign Overflow = ovf_q;
`endif

    assign InReady = (fifo_count != CNT_W'(DEPTH));
    assign Load    = load_q;
    assign Clear   = clear_q;
    assign OutData = out_q;
    assign Count   = fifo_count;
    assign Busy    = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_load_sequencer.sv
// Directed testbench for load_sequencer (N=4, DEPTH=4, GAP=1).
// Inputs are driven 1 ns after a rising edge, and outputs are checked at that
// same point.
module tb_load_sequencer;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int GAP   = 1;

    logic         Clock = 1'b0;
    logic         ResetN;
    logic         InValid;
    logic [N-1:0] InData;
    logic         InReady;
    logic         ClearReq;
    logic         Load;
    logic         Clear;
    logic [N-1:0] OutData;
    logic [2:0]   Count;
    logic         Busy;
`ifdef LOAD_SEQUENCER_OVF_EN
    logic         Overflow;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected values after each edge of the six-word burst (edges 0..5).
    logic [2:0]   t3_cnt [6] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
    logic         t3_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic         t3_ld  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [N-1:0] t3_out [6] = '{4'hA, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2};

    load_sequencer #(.N(N), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .InValid  (InValid),
        .InData   (InData),
        .InReady  (InReady),
        .ClearReq (ClearReq),
        .Load     (Load),
        .Clear    (Clear),
        .OutData  (OutData),
        .Count    (Count),
        .Busy     (Busy)
`ifdef LOAD_SEQUENCER_OVF_EN
        ,
        .Overflow (Overflow)
`endif
    );

    // Clock and run-time guard
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the next Load pulse. Then it checks the number of
    // cycles waited and the word presented during that pulse.
    task automatic wait_load(input string tag, input logic [N-1:0] exp_data, input int exp_wait);
        int waited;
        waited = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (Load === 1'b1) begin
                waited = i;
                break;
            end
        end
        chk({tag, "_wait"}, waited, exp_wait);
        chk({tag, "_data"}, OutData, exp_data);
    endtask

    initial begin
        // 1: reset held for two edges while InValid is high
        ResetN   = 1'b0;
        InValid  = 1'b1;
        InData   = 4'h5;
        ClearReq = 1'b0;
        tick();
        tick();
        chk("rst_load", Load, 0);
        chk("rst_clear", Clear, 0);
        chk("rst_out", OutData, 0);
        chk("rst_count", Count, 0);
        ResetN  = 1'b1;
        InValid = 1'b0;
        #1;
        chk("rst_ready", InReady, 1);
        chk("rst_busy", Busy, 0);

        // 2: a single word 4'hA pushed at edge k
        InValid = 1'b1;
        InData  = 4'hA;
        tick();                                   // edge k
        InValid = 1'b0;
        chk("single_k_count", Count, 1);
        chk("single_k_load", Load, 0);
        chk("single_k_out", OutData, 0);
        tick();                                   // edge k+1: SETUP
        chk("single_k1_out", OutData, 4'hA);
        chk("single_k1_load", Load, 0);
        tick();                                   // edge k+2: LOAD
        chk("single_k2_load", Load, 1);
        chk("single_k2_out", OutData, 4'hA);
        tick();                                   // edge k+3: pop, HOLD
        chk("single_k3_load", Load, 0);
        chk("single_k3_count", Count, 0);
        tick();                                   // edge k+4: IDLE
        chk("single_k4_busy", Busy, 0);
        chk("single_k4_out", OutData, 4'hA);

        // 3: burst 1..6 back to back; word 6 meets a full FIFO and is dropped
        InValid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            InData = 4'(i + 1);
            tick();
            chk($sformatf("burst_e%0d_count", i), Count, t3_cnt[i]);
            chk($sformatf("burst_e%0d_ready", i), InReady, t3_rdy[i]);
            chk($sformatf("burst_e%0d_load", i), Load, t3_ld[i]);
            chk($sformatf("burst_e%0d_out", i), OutData, t3_out[i]);
        end
        InValid = 1'b0;
        wait_load("burst_w3", 4'h3, 3);
        wait_load("burst_w4", 4'h4, 3);
        wait_load("burst_w5", 4'h5, 3);
        tick();
        chk("burst_drain_count", Count, 0);
        tick();
        chk("burst_drain_busy", Busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("burst_no6_load%0d", i), Load, 0);
        end

        // 4: ClearReq during LOAD with three words queued, plus a push on the same edge
        InValid = 1'b1;
        InData  = 4'h7;
        tick();
        InData  = 4'h8;
        tick();
        InData  = 4'h9;
        tick();                                   // LOAD of 4'h7
        chk("clr_pre_load", Load, 1);
        chk("clr_pre_count", Count, 3);
        ClearReq = 1'b1;
        InData   = 4'hB;
        tick();
        chk("clr_clear", Clear, 1);
        chk("clr_load", Load, 0);
        chk("clr_count", Count, 0);
        chk("clr_out", OutData, 0);
        chk("clr_busy", Busy, 0);
        chk("clr_ready", InReady, 1);
        ClearReq = 1'b0;
        InValid  = 1'b0;
        tick();
        chk("clr_after_clear", Clear, 0);
        chk("clr_after_count", Count, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("clr_no_load%0d", i), Load, 0);
        end
        ClearReq = 1'b1;
        tick();
        chk("clr_hold_1", Clear, 1);
        tick();
        chk("clr_hold_2", Clear, 1);
        ClearReq = 1'b0;
        tick();
        chk("clr_hold_end", Clear, 0);

        // 5: a push on the pop edge while two words are queued
        InValid = 1'b1;
        InData  = 4'h1;
        tick();
        InData  = 4'h2;
        tick();                                   // SETUP of 4'h1
        InValid = 1'b0;
        tick();                                   // LOAD of 4'h1
        chk("pp_load", Load, 1);
        chk("pp_out", OutData, 4'h1);
        chk("pp_count_pre", Count, 2);
        InValid = 1'b1;
        InData  = 4'hC;
        tick();                                   // pop of 4'h1 and push of 4'hC
        InValid = 1'b0;
        chk("pp_count_same", Count, 2);
        chk("pp_load_off", Load, 0);
        wait_load("pp_w2", 4'h2, 2);
        wait_load("pp_wc", 4'hC, 3);
        tick();
        tick();
        chk("pp_end_count", Count, 0);
        chk("pp_end_busy", Busy, 0);

`ifdef LOAD_SEQUENCER_OVF_EN
        // 6: a push while the FIFO is full sets the sticky Overflow flag
        InValid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            InData = 4'(i + 8);
            tick();
            if (i == 4) chk("ovf_before", Overflow, 0);
        end
        InValid = 1'b0;
        chk("ovf_set", Overflow, 1);
        tick();
        tick();
        tick();
        chk("ovf_sticky", Overflow, 1);
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        chk("ovf_cleared", Overflow, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
